// File: rtl/ifu_inst_queue_if.sv
// Handshake bundle between the fetch request stage, the instruction bus return
// path and decode, as seen by the instruction queue.
interface ifu_inst_queue_if;
  logic        addrValid_i;
  logic [31:0] addr_i;
  logic        addrReady_o;
  logic        dataOk_i;
  logic [31:0] instData_i;
  logic        jumpFlag_i;
  logic        decValid_o;
  logic [31:0] decInst_o;
  logic [31:0] decAddr_o;
  logic        decReady_i;

  modport slave (
    input  addrValid_i, addr_i, dataOk_i, instData_i, jumpFlag_i, decReady_i,
    output addrReady_o, decValid_o, decInst_o, decAddr_o
  );

  modport master (
    output addrValid_i, addr_i, dataOk_i, instData_i, jumpFlag_i, decReady_i,
    input  addrReady_o, decValid_o, decInst_o, decAddr_o
  );
endinterface

// File: rtl/ifu_inst_queue.sv
// Fetch instruction queue: pairs issued addresses with in-order bus returns and
// feeds decode. Optional sticky protocol error output under IFU_IQ_ERR_CHECK_EN.
module ifu_inst_queue #(
  parameter int Depth    = 4,
  parameter int TagDepth = 4
) (
  input  logic              clk,
  input  logic              reset,
  ifu_inst_queue_if.slave   bus
`ifdef IFU_IQ_ERR_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int QAW = $clog2(Depth);
  localparam int TAW = $clog2(TagDepth);
  localparam int SW  = TAW + 2;

  logic [QAW:0] q_wr, q_rd, qCnt;
  logic [TAW:0] pend_wr, pend_rd, pendCnt, discardCnt;

  logic [31:0] q_addr_mem [Depth];
  logic [31:0] q_inst_mem [Depth];
  logic [31:0] pend_mem   [TagDepth];

  logic [SW-1:0] credit_sum;
  logic          addr_push;
  logic          ret_discard;
  logic          ret_take;
  logic          q_push;
  logic          q_pop;

  // Credits cover both outstanding requests and buffered words, so a
  // returned word always finds a queue slot.
  assign credit_sum       = SW'(pendCnt) + SW'(qCnt);
  assign bus.addrReady_o  = (credit_sum < SW'(Depth)) &&
                            (pendCnt < (TAW+1)'(TagDepth));

  assign addr_push   = bus.addrValid_i & bus.addrReady_o & ~bus.jumpFlag_i;
  assign ret_discard = bus.dataOk_i & (discardCnt != '0);
  assign ret_take    = bus.dataOk_i & (discardCnt == '0) & (pendCnt != '0);
  assign q_push      = ret_take & ~bus.jumpFlag_i;
  assign q_pop       = bus.decValid_o & bus.decReady_i & ~bus.jumpFlag_i;

  assign bus.decValid_o = (qCnt != '0);
  assign bus.decAddr_o  = bus.decValid_o ? q_addr_mem[q_rd[QAW-1:0]] : '0;
  assign bus.decInst_o  = bus.decValid_o ? q_inst_mem[q_rd[QAW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wr       <= '0;
      q_rd       <= '0;
      qCnt       <= '0;
      pend_wr    <= '0;
      pend_rd    <= '0;
      pendCnt    <= '0;
      discardCnt <= '0;
    end else if (bus.jumpFlag_i) begin
      // Every request still on the bus becomes a word to throw away; a return
      // arriving this cycle has already been charged against the old state.
      q_wr       <= '0;
      q_rd       <= '0;
      qCnt       <= '0;
      pend_wr    <= '0;
      pend_rd    <= '0;
      pendCnt    <= '0;
      discardCnt <= discardCnt + pendCnt - (TAW+1)'(ret_take)
                    - (TAW+1)'(ret_discard);
    end else begin
      pend_wr    <= pend_wr + (TAW+1)'(addr_push);
      pend_rd    <= pend_rd + (TAW+1)'(ret_take);
      pendCnt    <= pendCnt + (TAW+1)'(addr_push) - (TAW+1)'(ret_take);
      q_wr       <= q_wr + (QAW+1)'(q_push);
      q_rd       <= q_rd + (QAW+1)'(q_pop);
      qCnt       <= qCnt + (QAW+1)'(q_push) - (QAW+1)'(q_pop);
      discardCnt <= discardCnt - (TAW+1)'(ret_discard);
    end
  end

  // Storage carries no reset; validity is tracked by the counts above.
  always_ff @(posedge clk) begin
    if (addr_push) begin
      pend_mem[pend_wr[TAW-1:0]] <= bus.addr_i;
    end
    if (q_push) begin
      q_addr_mem[q_wr[QAW-1:0]] <= pend_mem[pend_rd[TAW-1:0]];
      q_inst_mem[q_wr[QAW-1:0]] <= bus.instData_i;
    end
  end

`ifdef IFU_IQ_ERR_CHECK_EN
  logic ret_spur;
  assign ret_spur = bus.dataOk_i & (discardCnt == '0) & (pendCnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (ret_spur | (bus.addrValid_i & ~bus.addrReady_o)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule
